// File: rtl/pipe_stage_reg_if.sv
// Stream bus between the upstream producer, the pipeline stage register and the downstream consumer.
// A beat moves on a rising edge when its valid and ready are both high; valid never waits on ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, synchronous flush
// and a saturating count of entries discarded by flush.
module pipe_stage_reg #(
    parameter int DATA_W  = 96,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W:0]    drop_sum;
    logic              accept;
    logic              consume;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic in_ready_q;
            // Registered from the next state so upstream never sees a path from out_ready.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) in_ready_q <= 1'b1;
                else       in_ready_q <= (state_d != SKID);
            end
            assign bus.in_ready = in_ready_q;
        end else begin : g_noskid
            assign bus.in_ready = !bus.out_valid | bus.out_ready;
        end
    endgenerate

    assign accept        = bus.in_valid & bus.in_ready;
    assign consume       = bus.out_valid & bus.out_ready;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = main_q;
    assign drop_cnt      = drop_q;
    assign dbg_state     = state_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            FULL:    occupancy = 2'd1;
            SKID:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign drop_sum = {1'b0, drop_q} + (CNT_W+1)'(occupancy);

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        drop_d  = drop_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
            drop_d  = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = bus.in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    case ({accept, consume})
                        2'b11: main_d  = bus.in_data;
                        2'b01: state_d = EMPTY;
                        2'b10: begin
                            if (SKID_EN != 0) begin
                                skid_d  = bus.in_data;
                                state_d = SKID;
                            end
                        end
                        default: ;
                    endcase
                end
                SKID: begin
                    if (consume) begin
                        main_d  = skid_q;
                        state_d = FULL;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            drop_q  <= drop_d;
        end
    end

endmodule
